// File: rtl/apb_master.sv
// APB master: turns single command-side requests into APB SETUP/ACCESS
// transfers, with optional wait-state timeout and a one-cycle response pulse.
//
// state  | meaning
// IDLE   | bus idle, request accepted immediately
// SETUP  | psel asserted, penable low, one cycle only
// ACCESS | psel and penable high, waiting for pready or timeout
module apb_master #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [DATA_WIDTH-1:0] prdata
);

  // With the timeout disabled the counter still needs at least one bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             timeout_hit;

  // A new request can be taken when idle or in the completing ACCESS cycle.
  always_comb begin
    req_ready   = presetn && ((state == IDLE) || ((state == ACCESS) && pready));
    accept      = req_valid && req_ready;
    timeout_hit = (TIMEOUT_CYCLES > 0) && (state == ACCESS) && !pready &&
                  (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
  end

  // Transfer sequencing, wait counting and response registration.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
        end
        SETUP: begin
          state    <= ACCESS;
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid   <= 1'b1;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= pwrite ? '0 : prdata;
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwdata      <= '0;
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwdata      <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
          pwdata  <= '0;
        end
      endcase
      // An accepted request (idle or back-to-back) overrides the return to IDLE.
      if (accept) begin
        state   <= SETUP;
        psel    <= 1'b1;
        penable <= 1'b0;
        paddr   <= req_addr;
        pwrite  <= req_write;
        pwdata  <= req_write ? req_wdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: the bench plays the APB slave, predicts each
// response from the transfer parameters, and checks bus timing per cycle.
module tb_apb_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic          pslverr;
  logic [DW-1:0] prdata;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_seen = 0;
  int rsp_exp  = 0;

  always #5 pclk = ~pclk;

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata)
  );

  // Count every response pulse so spurious or missing ones show up at the end.
  always @(negedge pclk) if (rsp_valid === 1'b1) rsp_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated transfer. waits = number of ACCESS cycles with pready=0
  // before the slave answers; beyond TO the master must abort at TO.
  task automatic run_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                          input int waits, input logic serr, input logic [DW-1:0] rd);
    bit            abort;
    int            k;
    bit            last;
    logic [DW-1:0] exp_pw;
    logic [DW-1:0] exp_rd;
    logic          exp_se;
    abort  = (waits > TO);
    k      = abort ? TO : waits;
    exp_pw = w ? wd : '0;
    exp_rd = (abort || w) ? '0 : rd;
    exp_se = abort ? 1'b1 : serr;

    @(negedge pclk);
    check("idle_psel", 32'(psel), 32'd0);
    check("idle_penable", 32'(penable), 32'd0);
    check("idle_pwdata", pwdata, 32'd0);
    pready    = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = wd;
    #1 check("idle_ready", 32'(req_ready), 32'd1);

    @(negedge pclk);
    check("setup_psel", 32'(psel), 32'd1);
    check("setup_penable", 32'(penable), 32'd0);
    check("setup_paddr", 32'(paddr), 32'(a));
    check("setup_pwrite", 32'(pwrite), 32'(w));
    check("setup_pwdata", pwdata, exp_pw);
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_write = 1'($urandom);
    req_wdata = $urandom;
    #1 check("setup_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i <= k; i++) begin
      @(negedge pclk);
      check("acc_psel", 32'(psel), 32'd1);
      check("acc_penable", 32'(penable), 32'd1);
      check("acc_paddr", 32'(paddr), 32'(a));
      check("acc_pwrite", 32'(pwrite), 32'(w));
      check("acc_pwdata", pwdata, exp_pw);
      check("acc_rsp_valid", 32'(rsp_valid), 32'd0);
      last    = !abort && (i == waits);
      pready  = last;
      pslverr = last ? serr : 1'($urandom);
      prdata  = last ? rd : $urandom;
      #1 check("acc_ready", 32'(req_ready), 32'(last));
    end

    @(negedge pclk);
    rsp_exp++;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_slverr", 32'(rsp_slverr), 32'(exp_se));
    check("rsp_timeout", 32'(rsp_timeout), 32'(abort));
    check("end_psel", 32'(psel), 32'd0);
    check("end_penable", 32'(penable), 32'd0);
    check("end_paddr_held", 32'(paddr), 32'(a));
    check("end_pwdata", pwdata, 32'd0);
    pready  = 1'b0;
    pslverr = 1'($urandom);
    prdata  = $urandom;

    @(negedge pclk);
    check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    check("rsp_rdata_hold", rsp_rdata, exp_rd);
    check("rsp_slverr_hold", 32'(rsp_slverr), 32'(exp_se));
    check("rsp_timeout_hold", 32'(rsp_timeout), 32'(abort));
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;

    presetn   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;

    repeat (3) @(negedge pclk);
    req_valid = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_slverr", 32'(rsp_slverr), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    req_valid = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;

    // Directed cases: zero-wait write, 3-wait read, timeout, slave error, tie.
    run_xfer(10'h3A5, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'hCAFEF00D);
    run_xfer(10'h010, 1'b0, 32'h0, 3, 1'b0, 32'h12345678);
    run_xfer(10'h155, 1'b0, 32'h0, 100, 1'b0, 32'h0BADF00D);
    run_xfer(10'h2AA, 1'b1, 32'h5555AAAA, 1, 1'b1, 32'h0);
    run_xfer(10'h0F0, 1'b0, 32'h0, TO, 1'b1, 32'hA5A5A5A5);

    // Back-to-back read then write with req_valid held.
    ra = 10'h044;
    wa = 10'h388;
    wd = 32'h0F1E2D3C;
    rd = 32'h89ABCDEF;
    @(negedge pclk);
    req_valid = 1'b1;
    req_addr  = ra;
    req_write = 1'b0;
    req_wdata = $urandom;
    @(negedge pclk);
    check("b2b_setup1_paddr", 32'(paddr), 32'(ra));
    check("b2b_setup1_pwdata", pwdata, 32'd0);
    req_addr  = wa;
    req_write = 1'b1;
    req_wdata = wd;
    #1 check("b2b_setup1_ready", 32'(req_ready), 32'd0);
    @(negedge pclk);
    check("b2b_acc1_penable", 32'(penable), 32'd1);
    check("b2b_acc1_paddr", 32'(paddr), 32'(ra));
    pready  = 1'b1;
    pslverr = 1'b0;
    prdata  = rd;
    #1 check("b2b_acc1_ready", 32'(req_ready), 32'd1);
    @(negedge pclk);
    rsp_exp++;
    check("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rsp1_rdata", rsp_rdata, rd);
    check("b2b_setup2_psel", 32'(psel), 32'd1);
    check("b2b_setup2_penable", 32'(penable), 32'd0);
    check("b2b_setup2_paddr", 32'(paddr), 32'(wa));
    check("b2b_setup2_pwrite", 32'(pwrite), 32'd1);
    check("b2b_setup2_pwdata", pwdata, wd);
    req_valid = 1'b0;
    pready    = 1'b0;
    @(negedge pclk);
    check("b2b_acc2_penable", 32'(penable), 32'd1);
    check("b2b_acc2_rsp_valid", 32'(rsp_valid), 32'd0);
    pready = 1'b1;
    prdata = $urandom;
    @(negedge pclk);
    rsp_exp++;
    check("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rsp2_rdata", rsp_rdata, 32'd0);
    check("b2b_rsp2_slverr", 32'(rsp_slverr), 32'd0);
    check("b2b_end_psel", 32'(psel), 32'd0);
    pready = 1'b0;

    // Reset in the middle of an ACCESS phase drops the transfer.
    @(negedge pclk);
    req_valid = 1'b1;
    req_addr  = 10'h123;
    req_write = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    check("mid_acc_penable", 32'(penable), 32'd1);
    pready  = 1'b0;
    presetn = 1'b0;
    #1 check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge pclk);
    check("mid_rst_psel", 32'(psel), 32'd0);
    check("mid_rst_penable", 32'(penable), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_paddr", 32'(paddr), 32'd0);
    presetn = 1'b1;
    #1 check("post_rst_ready", 32'(req_ready), 32'd1);
    run_xfer(10'h321, 1'b1, 32'h13572468, 2, 1'b0, 32'h0);

    // Randomised transfers, including aborts and threshold ties.
    for (int n = 0; n < 40; n++) begin
      run_xfer(AW'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, TO + 2)),
               1'($urandom), $urandom);
    end

    repeat (2) @(negedge pclk);
    check("rsp_count", 32'(rsp_seen), 32'(rsp_exp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: APB address width.
REQ-002 Parameter DATA_WIDTH, default 32: APB data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum number of ACCESS wait cycles before abort; 0 disables the timeout.
REQ-004 pclk  input  1  single clock; all logic on its rising edge.
REQ-005 presetn  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  command-side request present.
REQ-007 req_ready  output  1  module accepts the request this cycle.
REQ-008 req_addr  input  ADDR_WIDTH  target address.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-013 rsp_slverr  output  1  slave error, or timeout abort.
REQ-014 rsp_timeout  output  1  transfer was aborted by the timeout.
REQ-015 psel, penable, pwrite  output  1 each  APB control signals.
REQ-016 paddr  output  ADDR_WIDTH; pwdata  output  DATA_WIDTH.
REQ-017 pready, pslverr  input  1 each; prdata  input  DATA_WIDTH.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP and ACCESS, encoded as a 2-bit enum.
REQ-019 req_ready SHALL be 1 in IDLE, and in ACCESS only in the cycle where pready=1; it SHALL be 0 otherwise, including on a timeout-abort cycle.
REQ-020 On req_valid&&req_ready, the address, write flag and write data SHALL be captured and the FSM SHALL go to SETUP on the next edge.
REQ-021 SETUP: psel=1, penable=0; the FSM SHALL go to ACCESS unconditionally after 1 cycle.
REQ-022 ACCESS: psel=1, penable=1; the FSM SHALL stay in ACCESS while pready=0.
REQ-023 paddr, pwrite and pwdata SHALL be stable from SETUP through the last ACCESS cycle.
REQ-024 pwdata SHALL carry the captured data for writes and SHALL be 0 for reads.
REQ-025 In ACCESS with pready=1:
  - prdata (reads only) and pslverr SHALL be registered.
  - rsp_valid SHALL be 1 on the next cycle for exactly 1 cycle, with rsp_timeout=0.
REQ-026 In ACCESS with pready=1, the next state SHALL be SETUP if a request is accepted in the same cycle (back-to-back), otherwise IDLE.
REQ-027 In IDLE, psel and penable SHALL be 0.
  - The previous transfer's paddr and pwrite SHALL be held.
  - pwdata SHALL be 0.
REQ-028 Latency SHALL be: accept at cycle N -> SETUP N+1 -> ACCESS N+2 -> with pready=1 at N+2, rsp_valid at N+3.
REQ-029 A wait counter, $clog2(TIMEOUT_CYCLES+1) bits wide, SHALL be cleared on entry to ACCESS and SHALL increment on each ACCESS cycle with pready=0, saturating.
REQ-030 When TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES while pready=0, the FSM SHALL abort:
  - next state IDLE; psel and penable SHALL be 0 on the next cycle.
  - rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
REQ-031 When pready=1 is sampled in the same cycle as the timeout threshold, the normal completion SHALL take priority over the abort.
REQ-032 pslverr SHALL be used only when pready=1; rsp_rdata for a read with pslverr=1 SHALL still be the sampled prdata.
REQ-033 rsp_rdata, rsp_slverr and rsp_timeout SHALL hold their values until the next rsp_valid.

Reset
REQ-034 While presetn=0 at a rising edge, the next state SHALL be:
  - FSM in IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_slverr and rsp_timeout = 0.
  - paddr, pwdata and rsp_rdata = 0; wait counter = 0.
REQ-035 A reset asserted during SETUP or ACCESS SHALL drop the transfer with no rsp_valid; psel=0 from the next edge.
REQ-036 req_ready SHALL be 0 while presetn=0.

Verification
REQ-037 Zero-wait write: addr=0x3A5, wdata=0xDEADBEEF, pready=1 in ACCESS -> APB shows SETUP then ACCESS with stable paddr and pwdata; rsp_valid at N+3 with rsp_slverr=0 and rsp_rdata=0.
REQ-038 Read with 3 wait states: addr=0x010, prdata=0x12345678 presented with pready on the 4th ACCESS cycle -> penable held for 4 cycles; rsp_rdata=0x12345678 at N+6.
REQ-039 Back-to-back: read then write with req_valid held -> ACCESS is followed directly by SETUP with no IDLE cycle; exactly two rsp_valid pulses, in order.
REQ-040 Timeout: TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 wait cycles; rsp_valid with rsp_slverr=1, rsp_timeout=1 and rsp_rdata=0; then IDLE.
REQ-041 Slave error and tie: pslverr=1 with pready=1 -> rsp_slverr=1 and rsp_timeout=0; pready=1 on the threshold cycle -> normal completion with rsp_timeout=0.
REQ-042 Reset mid-ACCESS: presetn=0 for 1 cycle while pready=0 -> psel=0 from the next edge, no rsp_valid; a new request is accepted in IDLE afterwards.
